// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, downstream controls and IF/ID outputs.
// master = fetch stage, slave = pipeline/memory side.
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_in;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_pred_taken;
  logic        fetch_halted;
  logic        fetch_fault;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  redirect,
    input  redirect_pc,
    input  halt_in,
    output if_id_valid,
    output if_id_pc,
    output if_id_inst,
    output if_id_pred_taken,
    output fetch_halted,
    output fetch_fault
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output redirect,
    output redirect_pc,
    output halt_in,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_inst,
    input  if_id_pred_taken,
    input  fetch_halted,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, imem address and IF/ID register with sticky HALT/FAULT.
// Optional static branch/jump prediction is enabled by defining STATIC_PREDICT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic clk,
  input  logic rst,
  fetch_stage_if.master bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_HALT  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] inst_q, inst_d;
  logic        pred_q, pred_d;

  logic [31:0] seq_pc;
  logic        predict_taken;
  logic [31:0] predict_target;

  assign seq_pc = pc_q + 32'd4;

`ifdef STATIC_PREDICT_EN
  logic [6:0]  opcode;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic        is_bwd_branch;
  logic        is_jal;

  assign opcode        = bus.imem_data[6:0];
  assign b_imm         = {{20{bus.imem_data[31]}}, bus.imem_data[7], bus.imem_data[30:25],
                          bus.imem_data[11:8], 1'b0};
  assign j_imm         = {{12{bus.imem_data[31]}}, bus.imem_data[19:12], bus.imem_data[20],
                          bus.imem_data[30:21], 1'b0};
  assign is_bwd_branch = (opcode == 7'b1100011) && bus.imem_data[31];
  assign is_jal        = (opcode == 7'b1101111);
  assign predict_taken = is_bwd_branch || is_jal;
  assign predict_target = pc_q + (is_jal ? j_imm : b_imm);
`else
  assign predict_taken  = 1'b0;
  assign predict_target = seq_pc;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    ifpc_d  = ifpc_q;
    inst_d  = inst_q;
    pred_d  = pred_q;

    if (state_q != S_RUN) begin
      valid_d = 1'b0;
      ifpc_d  = '0;
      inst_d  = NOP_WORD;
      pred_d  = 1'b0;
    end else if (bus.redirect) begin
      // Redirect outranks stall and halt_in; a misaligned target faults with the PC held.
      valid_d = 1'b0;
      ifpc_d  = '0;
      inst_d  = NOP_WORD;
      pred_d  = 1'b0;
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state_d = S_FAULT;
      end else begin
        pc_d = bus.redirect_pc;
      end
    end else if (bus.halt_in && !bus.stall) begin
      state_d = S_HALT;
      valid_d = 1'b0;
      ifpc_d  = '0;
      inst_d  = NOP_WORD;
      pred_d  = 1'b0;
    end else if (!bus.stall) begin
      valid_d = 1'b1;
      ifpc_d  = pc_q;
      inst_d  = bus.imem_data;
      pred_d  = predict_taken;
      pc_d    = predict_taken ? predict_target : seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      ifpc_q  <= '0;
      inst_q  <= NOP_WORD;
      pred_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ifpc_q  <= ifpc_d;
      inst_q  <= inst_d;
      pred_q  <= pred_d;
    end
  end

  assign bus.imem_addr        = pc_q;
  assign bus.if_id_valid      = valid_q;
  assign bus.if_id_pc         = ifpc_q;
  assign bus.if_id_inst       = inst_q;
  assign bus.if_id_pred_taken = pred_q;
  assign bus.fetch_halted     = (state_q == S_HALT);
  assign bus.fetch_fault      = (state_q == S_FAULT);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32I CPU: owns the PC, drives the instruction-memory read address, and fills the IF/ID pipeline register consumed by decode. It sits directly upstream of decode and accepts stall, redirect and halt controls from downstream stages. Once a halt or fetch fault is latched, the stage freezes and issues only bubbles, so the pipeline drains before the top-level halt is observed.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0013, bubble instruction (addi x0,x0,0).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- imem_addr  out  32  fetch address; always equals the PC register.
- imem_data  in  32  instruction word; combinational read of imem_addr in the same cycle.
- stall  in  1  hold the PC and IF/ID (load-use hazard from decode).
- redirect  in  1  from EX: a taken branch, a jump, or a misprediction correction.
- redirect_pc  in  32  redirect target.
- halt_in  in  1  from decode: the instruction leaving ID is a halt or illegal instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of the IF/ID instruction.
- if_id_inst  out  32  IF/ID instruction word (NOP_WORD when not valid).
- if_id_pred_taken  out  1  fetch predicted this instruction taken.
- fetch_halted  out  1  stage is in HALT.
- fetch_fault  out  1  stage is in FAULT (misaligned redirect).

## Operation

- States: RUN, HALT, FAULT. Both HALT and FAULT are sticky; only rst exits them.
- RUN next-PC priority, highest first:
  - redirect: PC <= redirect_pc. IF/ID <= bubble.
  - halt_in with stall=0: go to HALT. The PC holds. IF/ID <= bubble.
  - stall: PC and IF/ID hold.
  - prediction (macro enabled only): see Configuration.
  - default: PC <= PC+4. IF/ID <= {valid=1, PC, imem_data}.
- halt_in while stall=1 is ignored, because the halting instruction has not yet left ID.
- redirect with redirect_pc[1:0] != 0: go to FAULT. The PC holds its old value. IF/ID <= bubble.
- In HALT and FAULT:
  - The PC is frozen and IF/ID holds a bubble every cycle.
  - redirect, stall and halt_in are ignored. No older instruction can still redirect once a halt is latched.
- Bubble = {valid=0, pc=0, inst=NOP_WORD, pred_taken=0}.
- Arithmetic: PC+4 and the branch/jump target adds are 32-bit, modulo 2^32. 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- Mid-operation reset (rst low) forces all state to its reset value immediately, regardless of the clock.

## Timing

- Reset values:
  - PC = imem_addr = RESET_PC.
  - State = RUN.
  - IF/ID = bubble.
  - fetch_halted = 0, fetch_fault = 0.
- Latency: the word at imem_addr=P appears on if_id_inst at the rising edge that ends the cycle P was presented. The first valid IF/ID entry follows the first rising edge after rst deasserts.
- Redirect penalty:
  - One bubble in IF/ID on the edge redirect is sampled.
  - The target instruction appears in IF/ID on the following edge.
- Redirect and stall together: redirect wins, and the stall is dropped for that edge.
- Redirect and halt_in together: redirect wins, and halt_in is ignored.
- fetch_halted and fetch_fault rise on the edge the transition is taken and stay registered outputs.

## Configuration

- STATIC_PREDICT_EN defined:
  - B-type fetch (opcode 1100011) with imem_data[31]=1 (backward branch): PC <= PC + B-immediate, if_id_pred_taken=1.
  - JAL fetch (opcode 1101111): PC <= PC + J-immediate, if_id_pred_taken=1.
  - All other fetches: if_id_pred_taken=0.
  - EX corrects any misprediction through redirect.
- STATIC_PREDICT_EN undefined:
  - The default next PC is always PC+4.
  - if_id_pred_taken is tied to 0.
  - No immediate-decode logic is present.

## Test plan

- Reset and sequential fetch: release rst with RESET_PC=0 and no controls asserted. Required: IF/ID shows (0x0,inst0), (0x4,inst1), (0x8,inst2) on successive edges, valid=1.
- Stall: at PC=0x8, assert stall for 2 cycles. Required: imem_addr holds 0x8, IF/ID holds (0x4,inst1), then the sequence resumes with 0x8.
- Redirect with stall: assert redirect=1, redirect_pc=0x40 and stall=1 in the same cycle. Required: a bubble (valid=0, inst=0x00000013) on that edge, then (0x40,inst) on the next.
- Halt:
  - Assert halt_in with stall=1. Required: no effect.
  - Then assert halt_in with stall=0. Required: fetch_halted=1, bubbles forever, and a later redirect does not change imem_addr.
- Fault and wrap:
  - redirect_pc=0x42. Required: fetch_fault=1 and imem_addr unchanged.
  - After reset, with RESET_PC=0xFFFF_FFFC. Required: the next imem_addr is 0x0000_0000.
- With STATIC_PREDICT_EN: at PC=0x20, fetch 0xFE000EE3 (beq x0,x0,-4). Required: next imem_addr=0x1C and if_id_pred_taken=1.
